// File: rtl/counter_bank.sv
// counter_bank: CHANNELS independent WIDTH-bit counters (free-run / auto-reload / one-shot) with tc pulse and sticky flag.
// Latency: every output is registered (one cycle); no backpressure, all inputs are sampled every cycle.
module counter_bank #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned STEP     = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         en_i,
  input  logic [CHANNELS-1:0]         dir_i,
  input  logic [2*CHANNELS-1:0]       mode_i,
  input  logic [CHANNELS-1:0]         set_i,
  input  logic [WIDTH*CHANNELS-1:0]   setValue_i,
  input  logic [WIDTH*CHANNELS-1:0]   limit_i,
  input  logic [CHANNELS-1:0]         clearFlag_i,
  output logic [WIDTH*CHANNELS-1:0]   count_o,
  output logic [CHANNELS-1:0]         tc_o,
  output logic [CHANNELS-1:0]         flag_o,
  output logic [CHANNELS-1:0]         running_o
);

  localparam logic [1:0]   MODE_RELOAD  = 2'b01;
  localparam logic [1:0]   MODE_ONESHOT = 2'b10;
  localparam logic [WIDTH:0] STEP_X     = (WIDTH+1)'(STEP);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             tc_q, tc_d;
    logic             flag_q, flag_d;

    logic [1:0]       mode;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] set_value;
    logic             one_shot, reload;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH-1:0] down_diff;
    logic             up_term, down_term;
    logic             advance, term;

    assign mode      = mode_i[2*n +: 2];
    assign limit     = limit_i[WIDTH*n +: WIDTH];
    assign set_value = setValue_i[WIDTH*n +: WIDTH];
    assign one_shot  = (mode == MODE_ONESHOT);
    assign reload    = (mode == MODE_RELOAD);

    // Terminal tests use one extra bit so the carry/borrow is explicit.
    assign up_sum    = {1'b0, count_q} + STEP_X;
    assign down_diff = count_q - STEP_X[WIDTH-1:0];
    assign down_term = ({1'b0, count_q} < STEP_X);
    assign up_term   = (one_shot || reload) ? (up_sum > {1'b0, limit}) : up_sum[WIDTH];

    assign advance = en_i[n] && !set_i[n] && !(one_shot && done_q);
    assign term    = advance && (dir_i[n] ? down_term : up_term);

    always_comb begin
      count_d = count_q;
      done_d  = done_q && one_shot;
      if (set_i[n]) begin
        count_d = set_value;
        done_d  = 1'b0;
      end else if (advance) begin
        if (!term) begin
          count_d = dir_i[n] ? down_diff : up_sum[WIDTH-1:0];
        end else if (reload) begin
          count_d = dir_i[n] ? limit : '0;
        end else if (one_shot) begin
          done_d = 1'b1;
        end else begin
          count_d = dir_i[n] ? down_diff : up_sum[WIDTH-1:0];
        end
      end
      tc_d   = term;
      flag_d = term || (flag_q && !clearFlag_i[n]);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count_q <= '0;
        done_q  <= 1'b0;
        tc_q    <= 1'b0;
        flag_q  <= 1'b0;
      end else begin
        count_q <= count_d;
        done_q  <= done_d;
        tc_q    <= tc_d;
        flag_q  <= flag_d;
      end
    end

    assign count_o[WIDTH*n +: WIDTH] = count_q;
    assign tc_o[n]                   = tc_q;
    assign flag_o[n]                 = flag_q;
    assign running_o[n]              = ~done_q;
  end

endmodule

// File: doc/counter_bank.md
# counter_bank

Multi-channel, parametrised successor to the single settable counter. Provides CHANNELS independent counters of WIDTH bits with per-channel enable, direction, load and mode (free-run, auto-reload, one-shot). Each channel has a terminal-count pulse and a sticky flag. Used as the shared timer/event-counter resource behind the user-project wishbone register file.

## Interface
- WIDTH, 32, counter width in bits (≥2)
- CHANNELS, 4, number of independent channels (≥1)
- STEP, 1, increment/decrement amount per enabled cycle (1 ≤ STEP < 2^WIDTH)
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset; asynchronous and active-high
- en_i  input  CHANNELS  per-channel count enable
- dir_i  input  CHANNELS  0 = count up, 1 = count down
- mode_i  input  2*CHANNELS  channel n uses bits [2n+1:2n]; 00 free-run, 01 auto-reload, 10 one-shot, 11 reserved (treated as free-run)
- set_i  input  CHANNELS  load setValue_i into channel
- setValue_i  input  WIDTH*CHANNELS  load values, channel n at [WIDTH*n +: WIDTH]
- limit_i  input  WIDTH*CHANNELS  per-channel limit / reload value, same packing
- clearFlag_i  input  CHANNELS  clear sticky flag
- count_o  output  WIDTH*CHANNELS  registered counts, same packing
- tc_o  output  CHANNELS  one-cycle terminal-count pulse
- flag_o  output  CHANNELS  sticky terminal-count flag
- running_o  output  CHANNELS  0 only while a one-shot channel is expired

## Operation
- Channels fully independent; description is per channel. count_r is the channel register; done_r is the internal one-shot-expired bit; running_o = ~done_r.
- Priority per cycle: set_i > counting > hold.
- set_i=1: count_r ← setValue_i; done_r ← 0; no terminal event that cycle, regardless of en_i.
- en_i=0 (and no set): count_r holds; no terminal event.
- Terminal detection, evaluated on enabled cycles, in WIDTH+1-bit arithmetic:
  - free-run up: carry out of count_r + STEP. Free-run down: count_r < STEP (borrow).
  - auto-reload/one-shot up: count_r + STEP > limit_i. Down: count_r < STEP.
- Next value on enabled cycle:
  - free-run: count_r ± STEP modulo 2^WIDTH; limit_i ignored.
  - auto-reload, terminal: up → 0, down → limit_i. Otherwise count_r ± STEP.
  - one-shot, not done: same as auto-reload, except on terminal count_r holds its current value and done_r ← 1.
  - one-shot, done: count_r holds, no further terminal events until set_i.
- done_r forced to 0 whenever mode_i is not one-shot.
- Terminal event → tc_o pulses high for exactly one cycle; flag_o ← 1.
- clearFlag_i clears flag_o; a terminal event in the same cycle wins (flag stays 1).
- limit_i, dir_i and mode_i are sampled each cycle; changes take effect at the next enabled cycle with no restart.
- Count register above limit_i in up reload modes (e.g. after set) → immediate terminal on next enabled cycle.

## Timing
- Reset (async, immediate): count_o=0, tc_o=0, flag_o=0, running_o=all 1s.
- All outputs are registered; there are no combinational input→output paths.
- Terminal-cycle edge: count_o shows reload/wrapped/held value, tc_o=1 and flag_o=1 on the same edge; running_o falls on that edge for one-shot.
- set_i: count_o = setValue_i one cycle after the set cycle; running_o rises on the same edge.
- Auto-reload up with STEP=1: period = limit_i + 1 cycles. Down: period = limit_i + 1 cycles.
- rst asserted mid-operation aborts everything. First count after release happens on the first rising edge with rst low.

## Test plan
- Reset: WIDTH=8, ch0 free-running at 0x37, pulse rst between edges → count_o=0, tc_o=0, flag_o=0, running_o=all 1s with no clock edge. Counting resumes 0,1,2 after release.
- Auto-reload up: limit=3, en=1 → count_o 0,1,2,3,0,1,2,3,0. tc_o high exactly on each 3→0 edge (every 4 cycles); flag_o set at the first wrap.
- One-shot down: set 5 → 5,4,3,2,1,0,0,0. tc_o single pulse where 0 is held, running_o 1→0 on that edge. Repeated set 2 → running_o=1, 2,1,0, then one more tc.
- Free-run up, WIDTH=8: set 0xFE → 0xFE,0xFF,0x00 with tc_o on the 0x00 edge. clearFlag_i asserted on the terminal cycle → flag_o stays 1. Later clearFlag_i alone → flag_o=0.
- STEP=4, auto-reload up, limit=10 → 0,4,8,0,4. Down, limit=10, set 10 → 10,6,2,10 with tc_o on the 2→10 edge.
- Independence/priority: ch0 set_i=1 (value 7) on its terminal cycle → count_o=7, no tc_o. ch1 with en_i=0 holds at 9 throughout. ch1 dir flipped mid-count reverses on the next enabled cycle.
